// File: rtl/display_scan_ctrl.sv
// Scan controller for a 4-digit common-anode hex display: frames a 16-bit value into
// nibble/anode pairs with dead time, leading-zero blanking and tear-free value updates.
module display_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 27000,
  parameter int unsigned DEADTIME    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value_i,
  input  logic        load_i,
  input  logic        blank_lz_i,
  output logic [3:0]  nibble_o,
  output logic        blank_o,
  output logic [3:0]  anode_o,
  output logic        frame_done_o
);

  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] DeadEnd  = PW'(DEADTIME);

  typedef enum logic {StIdle, StScan} state_e;

  state_e        state_q;
  logic [PW-1:0] presc_q;
  logic [1:0]    digit_q;
  logic [15:0]   active_q;
  logic [15:0]   pending_q;
  logic          pend_valid_q;

  logic       tick;
  logic       wrap;
  logic [3:0] cur_nib;
  logic [3:0] lz_blank;
  logic       dark;

  assign tick    = (presc_q == PrescMax);
  assign wrap    = tick && (digit_q == 2'd3);
  assign cur_nib = active_q[{digit_q, 2'b00} +: 4];

  // A digit is a leading zero when it and every more-significant nibble are zero.
  always_comb begin
    lz_blank    = 4'b0000;
    lz_blank[3] = blank_lz_i && (active_q[15:12] == 4'h0);
    lz_blank[2] = lz_blank[3] && (active_q[11:8] == 4'h0);
    lz_blank[1] = lz_blank[2] && (active_q[7:4] == 4'h0);
  end

  assign dark = (presc_q < DeadEnd) || lz_blank[digit_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      presc_q      <= '0;
      digit_q      <= 2'd0;
      active_q     <= 16'h0000;
      pending_q    <= 16'h0000;
      pend_valid_q <= 1'b0;
      nibble_o     <= 4'h0;
      blank_o      <= 1'b1;
      anode_o      <= 4'hF;
      frame_done_o <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          nibble_o     <= 4'h0;
          blank_o      <= 1'b1;
          anode_o      <= 4'hF;
          frame_done_o <= 1'b0;
          if (load_i) begin
            active_q <= value_i;
            presc_q  <= '0;
            digit_q  <= 2'd0;
            state_q  <= StScan;
          end
        end
        StScan: begin
          presc_q      <= tick ? '0 : presc_q + 1'b1;
          digit_q      <= tick ? digit_q + 2'd1 : digit_q;
          frame_done_o <= wrap;
          nibble_o     <= cur_nib;
          blank_o      <= dark;
          anode_o      <= dark ? 4'hF : ~(4'b0001 << digit_q);
          // Active only changes at frame boundaries so a frame never mixes two values.
          if (wrap && load_i) begin
            active_q     <= value_i;
            pend_valid_q <= 1'b0;
          end else if (wrap && pend_valid_q) begin
            active_q     <= pending_q;
            pend_valid_q <= 1'b0;
          end else if (load_i) begin
            pending_q    <= value_i;
            pend_valid_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: directed scenarios plus random traffic,
// compared cycle by cycle against a frame-arithmetic reference model.
module tb_display_scan_ctrl;

  localparam int RD = 4;
  localparam int DT = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value_i = 16'h0;
  logic        load_i = 1'b0;
  logic        blank_lz_i = 1'b0;
  logic [3:0]  nibble_o;
  logic        blank_o;
  logic [3:0]  anode_o;
  logic        frame_done_o;

  int errors = 0;
  int checks = 0;

  display_scan_ctrl #(
    .REFRESH_DIV(RD),
    .DEADTIME   (DT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .value_i     (value_i),
    .load_i      (load_i),
    .blank_lz_i  (blank_lz_i),
    .nibble_o    (nibble_o),
    .blank_o     (blank_o),
    .anode_o     (anode_o),
    .frame_done_o(frame_done_o)
  );

  always #5 clk = ~clk;

  wire [9:0] dut_out = {anode_o, blank_o, nibble_o, frame_done_o};
  localparam logic [9:0] DarkOut = 10'b1111_1_0000_0;

  // Reference model: m_n counts clocks since scanning began; the digit and the position
  // inside its period follow from division, the frame boundary from the remainder.
  logic        m_scan;
  int          m_n;
  logic [15:0] m_act;
  logic [15:0] m_pend;
  logic        m_pv;
  logic [9:0]  exp_out;
  int          m_dig;
  int          m_pr;
  logic        m_wrap;

  assign m_pr   = m_n % RD;
  assign m_dig  = (m_n / RD) % 4;
  assign m_wrap = m_scan && (m_pr == RD - 1) && (m_dig == 3);

  function automatic logic [9:0] model_out(input logic scan, input int n,
                                           input logic [15:0] act, input logic blz);
    int          pr;
    int          dg;
    logic [15:0] sh;
    logic        dark;
    logic [3:0]  an;
    if (!scan) return DarkOut;
    pr   = n % RD;
    dg   = (n / RD) % 4;
    sh   = act >> (4 * dg);
    dark = (pr < DT) || (blz && dg != 0 && sh == 16'h0);
    an   = dark ? 4'hF : ~(4'b0001 << dg);
    return {an, dark, sh[3:0], (pr == RD - 1) && (dg == 3)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_scan  <= 1'b0;
      m_n     <= 0;
      m_act   <= 16'h0;
      m_pend  <= 16'h0;
      m_pv    <= 1'b0;
      exp_out <= DarkOut;
    end else begin
      exp_out <= model_out(m_scan, m_n, m_act, blank_lz_i);
      if (!m_scan) begin
        if (load_i) begin
          m_scan <= 1'b1;
          m_act  <= value_i;
          m_n    <= 0;
        end
      end else begin
        m_n <= m_n + 1;
        if (m_wrap) begin
          if (load_i) begin
            m_act <= value_i;
            m_pv  <= 1'b0;
          end else if (m_pv) begin
            m_act <= m_pend;
            m_pv  <= 1'b0;
          end
        end else if (load_i) begin
          m_pend <= value_i;
          m_pv   <= 1'b1;
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    load_i = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (dut_out !== DarkOut)
      begin errors++; $display("FAIL reset_values: got %b want %b", dut_out, DarkOut); end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (dut_out !== DarkOut)
        begin errors++; $display("FAIL idle_dark c%0d: got %b want %b", i, dut_out, DarkOut); end
    end
  endtask

  task automatic test_scan();
    int fd_cnt = 0;
    blank_lz_i = 1'b0;
    value_i = 16'h1234;
    load_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      load_i = 1'b0;
      fd_cnt += int'(frame_done_o);
      checks++;
      if (dut_out !== exp_out)
        begin errors++; $display("FAIL scan c%0d: got %b want %b", i, dut_out, exp_out); end
    end
    checks++;
    if (fd_cnt != 3)
      begin errors++; $display("FAIL frame_done_count: got %0d want 3", fd_cnt); end
  endtask

  task automatic test_tearfree();
    int f0 = -1;
    bit done = 0;
    bit l1 = 0;
    bit l2 = 0;
    for (int i = 0; i < 160 && !done; i++) begin
      @(negedge clk);
      load_i = 1'b0;
      checks++;
      if (dut_out !== exp_out)
        begin errors++; $display("FAIL tearfree c%0d: got %b want %b", i, dut_out, exp_out); end
      if (f0 < 0 && m_dig == 1) begin
        f0 = m_n / 16; value_i = 16'hABCD; load_i = 1'b1;
      end else if (f0 >= 0 && !l1 && m_n / 16 == f0 + 2 && m_dig == 0) begin
        l1 = 1; value_i = 16'h1111; load_i = 1'b1;
      end else if (l1 && !l2 && m_dig == 2) begin
        l2 = 1; value_i = 16'h2222; load_i = 1'b1;
      end
      done = l2 && (m_n / 16 >= f0 + 4);
    end
    checks++;
    if (!done) begin errors++; $display("FAIL tearfree_timeout: got done=0 want 1"); end
  endtask

  task automatic test_lz();
    blank_lz_i = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      load_i = (i == 0) || (i == 40);
      value_i = (i < 40) ? 16'h0050 : 16'h0000;
      checks++;
      if (dut_out !== exp_out)
        begin errors++; $display("FAIL lz c%0d: got %b want %b", i, dut_out, exp_out); end
    end
    load_i = 1'b0;
    blank_lz_i = 1'b0;
  endtask

  task automatic test_wrap_load();
    bit fired = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      load_i = 1'b0;
      checks++;
      if (dut_out !== exp_out)
        begin errors++; $display("FAIL wrap_load c%0d: got %b want %b", i, dut_out, exp_out); end
      if (!fired && m_n % 16 == 5) begin
        value_i = 16'h1357; load_i = 1'b1;
      end else if (!fired && m_wrap && m_pv) begin
        fired = 1; value_i = 16'h9876; load_i = 1'b1;
      end
    end
    checks++;
    if (!fired) begin errors++; $display("FAIL wrap_load_timeout: got fired=0 want 1"); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      checks++;
      if (dut_out !== exp_out)
        begin errors++; $display("FAIL random c%0d: got %b want %b", i, dut_out, exp_out); end
      load_i = ($urandom_range(7) == 0);
      value_i = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(3)));
      blank_lz_i = 1'($urandom);
    end
    load_i = 1'b0;
    blank_lz_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit hit = 0;
    bit pended = 0;
    for (int i = 0; i < 80 && !hit; i++) begin
      @(negedge clk);
      load_i = 1'b0;
      checks++;
      if (dut_out !== exp_out)
        begin errors++; $display("FAIL pre_reset c%0d: got %b want %b", i, dut_out, exp_out); end
      if (!pended && m_dig == 0 && !m_wrap) begin
        pended = 1; value_i = 16'hFEED; load_i = 1'b1;
      end else if (pended && m_dig == 2 && m_pr == 1 && m_pv) begin
        hit = 1;
      end
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL reset_mid_timeout: got hit=0 want 1"); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dut_out !== DarkOut)
      begin errors++; $display("FAIL async_reset: got %b want %b", dut_out, DarkOut); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (dut_out !== DarkOut)
        begin errors++; $display("FAIL post_reset c%0d: got %b want %b", i, dut_out, DarkOut); end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_tearfree();
    test_lz();
    test_wrap_load();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Upstream feeder for the 4-bit-to-7-segment decode stage.
- Holds a 16-bit value (4 hex digits) and time-multiplexes it onto a 4-digit common-anode display.
- Each digit period it presents one nibble to the decoder and drives the matching active-low anode.
- Also handles tear-free value updates, anti-ghosting dead time and optional leading-zero blanking.

Parameters:
- REFRESH_DIV, 27000, clock cycles per digit period; legal range is 2 or more.
- DEADTIME, 2, cycles at the start of each digit period during which all anodes are off; legal range is 0 to REFRESH_DIV-1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- value_i  in  16  value to display; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- load_i  in  1  single-cycle strobe; captures value_i.
- blank_lz_i  in  1  1 = blank leading-zero digits 3..1.
- nibble_o  out  4  nibble to the decoder inputs A..D (A = bit 3).
- blank_o  out  1  1 = decoder segment outputs must be suppressed.
- anode_o  out  4  active-low digit enables; bit k = digit k.
- frame_done_o  out  1  one-cycle pulse when digit 3's period ends.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: anode_o=4'b1111, nibble_o=0, blank_o=1, frame_done_o=0. Prescaler=0, digit index=0, pending and active registers=0, state=IDLE.
- All outputs are registered.
- States:
  - IDLE: display dark (anodes 1111, blank_o=1).
  - SCAN: multiplexing.
- IDLE to SCAN: on load_i. value_i is written directly to the active register. Prescaler=0 and digit=0 on the next cycle.
- There is no path from SCAN back to IDLE except reset.
- Prescaler in SCAN:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - Tick = prescaler at REFRESH_DIV-1.
  - On a tick, digit advances 0,1,2,3,0.
- frame_done_o is 1 on the cycle after the tick that wraps digit 3 to 0.
- Within each digit period (registered, one-cycle output latency vs prescaler/digit):
  - Prescaler < DEADTIME: anode_o=1111, blank_o=1.
  - Otherwise: anode_o has only bit[digit] low, and nibble_o = active[4*digit+3 : 4*digit].
  - nibble_o follows the digit for the whole period, including dead time.
- Leading-zero blanking: with blank_lz_i=1, digit k (k=3..1) is blanked if active nibbles k..3 are all zero.
  - A blanked digit has blank_o=1 and its anode stays high.
  - Digit 0 is never blanked, so 0x0000 shows "0".
  - blank_lz_i is sampled combinationally each cycle; no latching.
- Tear-free update:
  - load_i in SCAN writes value_i to the pending register and sets pend_valid.
  - At the tick that wraps digit 3 to 0, if pend_valid: active <= pending and pend_valid <= 0.
  - Multiple loads in one frame: last wins.
  - load_i on the same cycle as the wrap tick: value_i goes straight to active, bypassing pending, and pend_valid is cleared.
- Reset mid-operation: immediate return to the reset values; the pending value is discarded.
- Width rules: prescaler width = $clog2(REFRESH_DIV). Digit index is 2 bits and wraps naturally.

Test Plan:
- Sim parameters: REFRESH_DIV=4, DEADTIME=1.
1. Reset, then no load for 20 cycles -> anode_o=1111, blank_o=1, frame_done_o never asserts.
2. Load 0x1234, blank_lz_i=0 -> digit periods of 4 cycles:
   - Digit 0: nibble 4, anode 1110 for cycles 2-4 of the period, 1111 in cycle 1.
   - Then nibble 3/1101, 2/1011, 1/0111.
   - frame_done_o pulses once every 16 cycles.
3. Scanning 0x1234, pulse load 0xABCD while digit 1 is shown -> remaining digits 2 and 3 still show 2 and 1. Next frame shows D,C,B,A. Then load 0x1111 and 0x2222 in the same frame -> the following frame shows 2222.
4. Load 0x0050, blank_lz_i=1 -> digits 3 and 2 blanked (anode high, blank_o=1); digits 1 and 0 show 5 and 0. Load 0x0000 -> only digit 0 lit, showing 0.
5. load_i coincident with the digit-3-to-0 wrap tick -> new value is shown starting at digit 0 of the immediately following frame.
6. Assert rst_n low mid-digit-2 while a load is pending -> outputs return to reset values at once. After release the block stays in IDLE, and the pending value is never displayed.
